bus_arbiter_ctrl: RTL
=====================

Name: bus_arbiter_ctrl

Overview:
- Central arbiter for the serial system bus.
- Chooses one of MASTER_COUNT requesting masters and sends the target slave's ID serially on the arbiter command line.
- Waits for that slave to acknowledge through its busy line, grants the bus to the master, and holds bus_util for the whole transaction.
- Sits between the masters and all slave wrappers; every slave's arbiter_cmd_in is driven by arbiter_cmd_out.

Parameters:
- MASTER_COUNT, 2, number of requesting masters (2..4).
- SLAVE_COUNT, 3, number of slaves; valid IDs are 0..SLAVE_COUNT-1.
- SLAVE_ID_WIDTH, 3, width of a slave ID in the serial select frame.
- ACK_TIMEOUT, 8, cycles to wait in ACK for the slave's busy before aborting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m_req  in  MASTER_COUNT  per-master bus request, level-held until done.
- m_slave_id  in  MASTER_COUNT*SLAVE_ID_WIDTH  target slave ID per master; master i uses slice [i*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH].
- m_done  in  MASTER_COUNT  one-cycle pulse from the granted master at transaction end.
- slave_busy  in  SLAVE_COUNT  busy_out of each slave.
- m_grant  out  MASTER_COUNT  one-hot grant.
- bus_util  out  1  bus in use; slaves return to idle when it is low.
- arbiter_cmd_out  out  1  serial select line to the slaves.
- arb_err  out  1  one-cycle pulse on an aborted selection.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer rr_ptr=0, all counters 0. Reset is honoured in any state; a frame in flight is dropped, and because bus_util falls the slaves release.
- States: IDLE, SEND, ACK, ACTIVE, RELEASE. All outputs are registered.
- IDLE:
  - If any m_req is high, pick the winner by round-robin: the first requester at or after rr_ptr, wrapping at MASTER_COUNT.
  - Latch the winner index and its slave ID, then go to SEND.
  - If the latched ID is >= SLAVE_COUNT, go to IDLE instead, pulse arb_err, and advance rr_ptr past that master.
- SEND lasts 1+SLAVE_ID_WIDTH cycles:
  - arbiter_cmd_out=1 (start bit) in the first cycle.
  - Then the ID bits, MSB first, one per cycle.
  - Then go to ACK with arbiter_cmd_out=0.
  - bus_util=1 from the first SEND cycle.
  - The frame is never truncated, even if the requesting master drops m_req.
- ACK:
  - arbiter_cmd_out=0 and an ack counter increments.
  - If slave_busy[id]=1, go to ACTIVE; m_grant[winner] rises in the first ACTIVE cycle.
  - If the counter reaches ACK_TIMEOUT, or m_req[winner]=0, go to RELEASE; arb_err pulses for the timeout case only.
- Latency: m_req rises in cycle 0 with the bus idle and the slave acks immediately. Start bit is in cycle 1, the last ID bit in cycle 1+SLAVE_ID_WIDTH, and the grant is visible in cycle 3+SLAVE_ID_WIDTH (6 with defaults).
- ACTIVE:
  - m_grant and bus_util are held.
  - m_done[winner]=1 or m_req[winner]=0 moves to RELEASE.
  - m_done from non-granted masters is ignored.
  - New requests wait.
- RELEASE: one cycle with m_grant=0 and bus_util=0; rr_ptr = winner+1 mod MASTER_COUNT; then IDLE. The bus is therefore idle for at least 1 cycle between transactions.
- Simultaneous events:
  - m_done and another master's m_req in the same cycle: the other master wins the next arbitration.
  - A master requesting continuously alternates with other active requesters; it is never granted twice in a row while another is requesting.
- m_grant is always one-hot or zero and is never asserted outside ACTIVE.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: IDLE selects the lowest-index requesting master (master 0 highest priority), and rr_ptr is neither used nor updated.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Decomposition:
- Shared package/header bus_arb_pkg holds:
  - state encodings (IDLE, SEND, ACK, ACTIVE, RELEASE);
  - START_BIT=1'b1;
  - the frame length constant 1+SLAVE_ID_WIDTH.
- The slave wrappers reuse the package to decode frames.
- One sub-module: arb_cmd_serializer, a load/shift register that produces the start bit plus MSB-first ID and a done flag; the FSM and arbitration stay in the top module.

Test Plan:
- Reset → all outputs 0. Master 0 requests slave 3'd2 and slave_busy[2] rises in the cycle after the last bit → arbiter_cmd_out shows 1,0,1,0 in cycles 1-4, m_grant=2'b01 in cycle 6, bus_util high over cycles 1 to ACTIVE end.
- Masters 0 and 1 request continuously, each pulsing m_done 4 cycles after grant → grants alternate 01,10,01,10. With ARB_FIXED_PRIORITY_EN, master 0 is granted every time.
- Master 1 targets slave 3'd1, which never raises busy → 8 ACK cycles, arb_err pulse, RELEASE with bus_util=0, m_grant never asserted.
- Master 0 requests slave ID 3'd5 with SLAVE_COUNT=3 → arb_err pulse from IDLE, no frame sent, master 1 served next.
- rstn pulled low mid-SEND (after 2 bits) → outputs 0 asynchronously. After release, a fresh request restarts the frame with its start bit.
- Master 0 drops m_req during ACTIVE without m_done → RELEASE next cycle, bus_util=0 for 1 cycle, rr_ptr=1.

Source files
------------

// File: rtl/bus_arbiter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the serial system bus arbiter and the slave wrappers
// that decode its select frames.
//   arb_state_e : arbiter FSM state encoding
//   START_BIT   : leading bit of every select frame
//   frame_len() : frame length in bits for a given slave ID width (1 + width)
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_ACK     = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    localparam logic START_BIT = 1'b1;

    localparam int SLAVE_ID_WIDTH_DEF = 3;

    function automatic int frame_len(input int id_w);
        return 1 + id_w;
    endfunction

    localparam int FRAME_LEN_DEF = frame_len(SLAVE_ID_WIDTH_DEF);

endpackage

// File: rtl/bus_arbiter_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_ctrl_if
// Bundle of master request/grant signals, slave busy lines and the serial
// select line around the bus arbiter.
//   m_req, m_slave_id, m_done : from masters
//   slave_busy                : busy_out of each slave
//   m_grant, bus_util         : grant/utilisation back to masters and slaves
//   arbiter_cmd_out, arb_err  : serial select line, abort pulse
// Modports:
//   slave  : the arbiter's view (consumes requests, drives grant/select)
//   master : the environment's view (drives requests, observes grant/select)
// -----------------------------------------------------------------------------
interface bus_arbiter_ctrl_if #(
    parameter int MASTER_COUNT   = 2,
    parameter int SLAVE_COUNT    = 3,
    parameter int SLAVE_ID_WIDTH = 3
);
    import bus_arb_pkg::*;

    logic [MASTER_COUNT-1:0]                m_req;
    logic [MASTER_COUNT*SLAVE_ID_WIDTH-1:0] m_slave_id;
    logic [MASTER_COUNT-1:0]                m_done;
    logic [SLAVE_COUNT-1:0]                 slave_busy;
    logic [MASTER_COUNT-1:0]                m_grant;
    logic                                   bus_util;
    logic                                   arbiter_cmd_out;
    logic                                   arb_err;

    modport slave (
        input  m_req, m_slave_id, m_done, slave_busy,
        output m_grant, bus_util, arbiter_cmd_out, arb_err
    );

    modport master (
        output m_req, m_slave_id, m_done, slave_busy,
        input  m_grant, bus_util, arbiter_cmd_out, arb_err
    );

endinterface

// File: rtl/bus_arbiter_ctrl_serializer.sv
// -----------------------------------------------------------------------------
// arb_cmd_serializer
// Load/shift register producing one select frame: the start bit followed by
// the slave ID, MSB first, one bit per shift. After the last ID bit has been
// shifted out the line returns to 0.
// Ports:
//   clk, rstn : clock, async active-low reset
//   load_i    : capture id_i and drive the start bit next cycle
//   shift_i   : advance the frame by one bit
//   id_i      : slave ID to send
//   ser_o     : registered serial output
//   done_o    : high while the last ID bit is on ser_o (no bits left)
// -----------------------------------------------------------------------------
module arb_cmd_serializer
    import bus_arb_pkg::*;
#(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [ID_W-1:0] id_i,
    output logic            ser_o,
    output logic            done_o
);

    localparam int FRAME_LEN = frame_len(ID_W);
    localparam int CNT_W     = $clog2(FRAME_LEN);

    logic [ID_W-1:0]  sreg_q;
    logic [CNT_W-1:0] cnt_q;   // ID bits still to be shifted out
    logic             ser_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            ser_q  <= 1'b0;
        end else if (load_i) begin
            ser_q  <= START_BIT;
            sreg_q <= id_i;
            cnt_q  <= CNT_W'(ID_W);
        end else if (shift_i) begin
            if (cnt_q != '0) begin
                ser_q  <= sreg_q[ID_W-1];
                sreg_q <= sreg_q << 1;
                cnt_q  <= cnt_q - CNT_W'(1);
            end else begin
                ser_q  <= 1'b0;
            end
        end
    end

    assign ser_o  = ser_q;
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// bus_arbiter_ctrl
// Central arbiter for the serial system bus. Picks one requesting master,
// sends the target slave ID as a serial frame, waits for that slave's busy
// acknowledge, grants the bus and holds bus_util until the transaction ends.
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : bus_arbiter_ctrl_if.slave (requests, busy, grant, select, error)
// Build option:
//   ARB_FIXED_PRIORITY_EN : lowest-index requester always wins; the
//                           round-robin pointer is ignored and never moves.
// -----------------------------------------------------------------------------
module bus_arbiter_ctrl
    import bus_arb_pkg::*;
#(
    parameter int MASTER_COUNT   = 2,
    parameter int SLAVE_COUNT    = 3,
    parameter int SLAVE_ID_WIDTH = 3,
    parameter int ACK_TIMEOUT    = 8
) (
    input  logic               clk,
    input  logic               rstn,
    bus_arbiter_ctrl_if.slave  bus
);

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam int PTR_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_e                state_q;
    logic [PTR_W-1:0]          rr_ptr_q;
    logic [PTR_W-1:0]          win_q;
    logic [SLAVE_ID_WIDTH-1:0] id_q;
    logic [ACK_W-1:0]          ack_cnt_q;
    logic [MASTER_COUNT-1:0]   grant_q;
    logic                      util_q;
    logic                      err_q;

    logic                      pick_vld_d;
    logic [PTR_W-1:0]          pick_idx_d;
    logic [SLAVE_ID_WIDTH-1:0] pick_id_d;
    logic                      id_bad_d;
    logic [PTR_W-1:0]          start_d;
    int                        idx;

    logic                      req_win;
    logic                      done_win;
    logic                      busy_sel;
    logic                      ser_load;
    logic                      ser_done;
    logic                      ser_cmd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MASTER_COUNT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // First requester at or after the start pointer, wrapping at MASTER_COUNT.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        pick_id_d  = '0;
        idx        = 0;
        start_d    = FIXED_PRIO ? '0 : rr_ptr_q;
        for (int k = 0; k < MASTER_COUNT; k++) begin
            idx = (int'(start_d) + k) % MASTER_COUNT;
            if (!pick_vld_d && bus.m_req[idx]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = PTR_W'(idx);
                pick_id_d  = bus.m_slave_id[idx*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH];
            end
        end
        id_bad_d = (int'(pick_id_d) >= SLAVE_COUNT);
    end

    // Signals of the latched winner and its target slave; decoded by compare
    // so that unused ID codes never index past the busy vector.
    always_comb begin
        req_win  = 1'b0;
        done_win = 1'b0;
        busy_sel = 1'b0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (win_q == PTR_W'(i)) begin
                req_win  = bus.m_req[i];
                done_win = bus.m_done[i];
            end
        end
        for (int s = 0; s < SLAVE_COUNT; s++) begin
            if (id_q == SLAVE_ID_WIDTH'(s)) busy_sel = bus.slave_busy[s];
        end
    end

    assign ser_load = (state_q == ST_IDLE) && pick_vld_d && !id_bad_d;

    arb_cmd_serializer #(.ID_W(SLAVE_ID_WIDTH)) u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (ser_load),
        .shift_i (state_q == ST_SEND),
        .id_i    (pick_id_d),
        .ser_o   (ser_cmd),
        .done_o  (ser_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            id_q      <= '0;
            ack_cnt_q <= '0;
            grant_q   <= '0;
            util_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        win_q <= pick_idx_d;
                        id_q  <= pick_id_d;
                        if (id_bad_d) begin
                            // No such slave: abort without a frame and let
                            // the next master have a turn.
                            err_q <= 1'b1;
                            if (!FIXED_PRIO) rr_ptr_q <= next_ptr(pick_idx_d);
                        end else begin
                            state_q <= ST_SEND;
                            util_q  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // Frame always runs to completion, even if m_req drops.
                    if (ser_done) begin
                        state_q   <= ST_ACK;
                        ack_cnt_q <= '0;
                    end
                end
                ST_ACK: begin
                    if (!req_win) begin
                        state_q <= ST_RELEASE;
                        util_q  <= 1'b0;
                    end else if (busy_sel) begin
                        state_q <= ST_ACTIVE;
                        grant_q <= MASTER_COUNT'(1) << win_q;
                    end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                        state_q <= ST_RELEASE;
                        util_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (done_win || !req_win) begin
                        state_q <= ST_RELEASE;
                        grant_q <= '0;
                        util_q  <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    if (!FIXED_PRIO) rr_ptr_q <= next_ptr(win_q);
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    util_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_grant         = grant_q;
    assign bus.bus_util        = util_q;
    assign bus.arbiter_cmd_out = ser_cmd;
    assign bus.arb_err         = err_q;

endmodule
